pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush with bubble insertion and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W = 64,
  parameter bit                SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkidf = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_accept;
  logic w_emit;

  assign out_valid = (r_state != StEmpty);
  // Hide stale main contents behind the bubble whenever nothing is valid.
  assign out_data  = out_valid ? r_main : BUBBLE;

  // With a skid buffer in_ready is a flop (breaks the ready path); without it,
  // ready passes straight through from downstream.
  assign in_ready  = SKID ? r_in_ready : (!out_valid || out_ready);

  assign w_accept  = in_valid && in_ready;
  assign w_emit    = out_valid && out_ready;

  // Handshake FSM, data registers and registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StEmpty;
      r_main     <= BUBBLE;
      r_skid     <= BUBBLE;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      // Kill everything held and anything arriving this cycle.
      r_state    <= StEmpty;
      r_main     <= BUBBLE;
      r_skid     <= BUBBLE;
      r_in_ready <= 1'b1;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_state <= StFull;
            r_main  <= in_data;
          end
        end
        StFull: begin
          if (w_accept && w_emit) begin
            r_main <= in_data;
          end else if (w_accept) begin
            // Only reachable with a skid buffer: downstream stalled, park the beat.
            if (SKID) begin
              r_state    <= StSkidf;
              r_skid     <= in_data;
              r_in_ready <= 1'b0;
            end
          end else if (w_emit) begin
            r_state <= StEmpty;
          end
        end
        StSkidf: begin
          if (w_emit) begin
            r_state    <= StFull;
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= StEmpty;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Saturating stall counter; clear wins over increment, flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != CntMax)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

  // Beats held, decoded from the FSM state.
  always_comb begin
    occupancy = 2'd0;
    unique case (r_state)
      StEmpty: occupancy = 2'd0;
      StFull:  occupancy = 2'd1;
      StSkidf: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
